// File: rtl/game_state_monitor.sv
// Per-frame outcome arbiter: Pac-Man vs N ghost box overlap, lives, respawn pause, win and game-over.
// Optional bonus life after EXTRA_LIFE_GHOSTS captures: define GAME_STATE_EXTRA_LIFE_EN.
module game_state_monitor #(
  parameter int N_GHOSTS          = 4,
  parameter int COORD_W           = 10,
  parameter int N_PELLETS         = 241,
  parameter int LIVES_W           = 3,
  parameter int START_LIVES       = 3,
  parameter int PAUSE_FRAMES      = 60,
  parameter int EXTRA_LIFE_GHOSTS = 8
) (
  input  logic                         Clk_i,
  input  logic                         Reset_n_i,
  input  logic                         Frame_tick_i,
  input  logic [N_GHOSTS*COORD_W-1:0]  X_ghost_i,
  input  logic [N_GHOSTS*COORD_W-1:0]  Y_ghost_i,
  input  logic [N_GHOSTS*COORD_W-1:0]  Size_ghost_i,
  input  logic [N_GHOSTS-1:0]          Ghost_frightened_i,
  input  logic [COORD_W-1:0]           X_pac_i,
  input  logic [COORD_W-1:0]           Y_pac_i,
  input  logic [COORD_W-1:0]           Size_pac_i,
  input  logic [N_PELLETS-1:0]         Not_ate_i,
  input  logic                         Restart_i,
  output logic                         Kill_o,
  output logic                         Win_o,
  output logic [LIVES_W-1:0]           Lives_o,
  output logic                         Life_lost_o,
  output logic [N_GHOSTS-1:0]          Ghost_eaten_o,
  output logic                         Respawn_o,
  output logic [1:0]                   State_o
);

  localparam int EW    = COORD_W + 1;
  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [LIVES_W-1:0] START_L = LIVES_W'(START_LIVES);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_OVER  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  state_t               state_q;
  logic [LIVES_W-1:0]   lives_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 kill_q;
  logic                 win_q;
  logic                 life_lost_q;
  logic [N_GHOSTS-1:0]  ghost_eaten_q;
  logic                 respawn_q;

  logic [N_GHOSTS-1:0]  overlap;
  logic [N_GHOSTS-1:0]  lethal;
  logic [N_GHOSTS-1:0]  capture;
  logic [EW-1:0]        pac_l, pac_r, pac_t, pac_b;

  // Low edge saturates at 0; high edge keeps the carry so boxes near 2^COORD_W never wrap.
  function automatic logic [EW-1:0] lo_edge(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] s);
    return (c >= s) ? {1'b0, c - s} : '0;
  endfunction

  function automatic logic [EW-1:0] hi_edge(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] s);
    return {1'b0, c} + {1'b0, s};
  endfunction

  always_comb begin
    pac_l   = lo_edge(X_pac_i, Size_pac_i);
    pac_r   = hi_edge(X_pac_i, Size_pac_i);
    pac_t   = lo_edge(Y_pac_i, Size_pac_i);
    pac_b   = hi_edge(Y_pac_i, Size_pac_i);
    overlap = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      overlap[i] = !((pac_l > hi_edge(X_ghost_i[i*COORD_W +: COORD_W], Size_ghost_i[i*COORD_W +: COORD_W])) ||
                     (pac_t > hi_edge(Y_ghost_i[i*COORD_W +: COORD_W], Size_ghost_i[i*COORD_W +: COORD_W])) ||
                     (pac_r < lo_edge(X_ghost_i[i*COORD_W +: COORD_W], Size_ghost_i[i*COORD_W +: COORD_W])) ||
                     (pac_b < lo_edge(Y_ghost_i[i*COORD_W +: COORD_W], Size_ghost_i[i*COORD_W +: COORD_W])));
    end
    lethal  = overlap & ~Ghost_frightened_i;
    capture = overlap &  Ghost_frightened_i;
  end

`ifdef GAME_STATE_EXTRA_LIFE_EN
  localparam int GC_W = $clog2(EXTRA_LIFE_GHOSTS + N_GHOSTS + 1);
  logic [GC_W-1:0]    gcnt_q;
  logic               award_q;
  logic [GC_W-1:0]    cap_cnt;
  logic               award_now;
  logic [LIVES_W-1:0] lives_bonus;

  always_comb begin
    cap_cnt = '0;
    for (int i = 0; i < N_GHOSTS; i++) cap_cnt = cap_cnt + GC_W'(capture[i]);
    award_now   = !award_q && ((gcnt_q + cap_cnt) >= GC_W'(EXTRA_LIFE_GHOSTS));
    lives_bonus = (&lives_q) ? lives_q : lives_q + LIVES_W'(1);
  end
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q       <= ST_PLAY;
      lives_q       <= START_L;
      cnt_q         <= '0;
      kill_q        <= 1'b0;
      win_q         <= 1'b0;
      life_lost_q   <= 1'b0;
      ghost_eaten_q <= '0;
      respawn_q     <= 1'b0;
`ifdef GAME_STATE_EXTRA_LIFE_EN
      gcnt_q        <= '0;
      award_q       <= 1'b0;
`endif
    end else begin
      life_lost_q   <= 1'b0;
      ghost_eaten_q <= '0;
      respawn_q     <= 1'b0;
      if (Frame_tick_i) begin
        // Restart outranks everything in every state.
        if (Restart_i) begin
          state_q <= ST_PLAY;
          lives_q <= START_L;
          cnt_q   <= '0;
          kill_q  <= 1'b0;
          win_q   <= 1'b0;
`ifdef GAME_STATE_EXTRA_LIFE_EN
          gcnt_q  <= '0;
          award_q <= 1'b0;
`endif
        end else begin
          case (state_q)
            ST_PLAY: begin
              if (|lethal) begin
                life_lost_q <= 1'b1;
                if (lives_q == LIVES_W'(1)) begin
                  lives_q <= '0;
                  state_q <= ST_OVER;
                  kill_q  <= 1'b1;
                end else begin
                  lives_q <= lives_q - LIVES_W'(1);
                  cnt_q   <= CNT_W'(PAUSE_FRAMES - 1);
                  state_q <= ST_PAUSE;
                end
              end else begin
                ghost_eaten_q <= capture;
                if (~|Not_ate_i) begin
                  state_q <= ST_WIN;
                  win_q   <= 1'b1;
                end
`ifdef GAME_STATE_EXTRA_LIFE_EN
                if (!award_q) gcnt_q <= gcnt_q + cap_cnt;
                if (award_now) begin
                  award_q <= 1'b1;
                  lives_q <= lives_bonus;
                end
`endif
              end
            end
            ST_PAUSE: begin
              if (cnt_q == '0) begin
                respawn_q <= 1'b1;
                state_q   <= ST_PLAY;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign State_o       = state_q;
  assign Lives_o       = lives_q;
  assign Kill_o        = kill_q;
  assign Win_o         = win_q;
  assign Life_lost_o   = life_lost_q;
  assign Ghost_eaten_o = ghost_eaten_q;
  assign Respawn_o     = respawn_q;

endmodule

// File: doc/game_state_monitor.md
Name: game_state_monitor

Overview:
- Per-frame game-outcome arbiter for the PacMan SoC. Sits between the sprite motion controllers and the top-level game controller.
- Checks the Pac-Man bounding box against N ghost bounding boxes. Separates lethal collisions from frightened-ghost captures.
- Tracks lives, a respawn pause, level-clear (win) and game-over.
- Successor to the single-ghost sticky kill flag: adds ghost count, lives, frightened mode and restart.

Parameters:
- N_GHOSTS, 4, number of ghost channels.
- COORD_W, 10, coordinate and size width.
- N_PELLETS, 241, width of the pellet-remaining vector.
- LIVES_W, 3, lives counter width.
- START_LIVES, 3, lives loaded at reset and on Restart.
- PAUSE_FRAMES, 60, frames held in PAUSE after a lethal hit.
- EXTRA_LIFE_GHOSTS, 8, ghost captures needed to earn the bonus life (optional feature only).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Frame_tick  in  1  one-cycle strobe; all evaluation happens only on cycles where it is high.
- X_ghost  in  N_GHOSTS*COORD_W  packed ghost centre X; ghost i occupies bits [i*COORD_W +: COORD_W].
- Y_ghost  in  N_GHOSTS*COORD_W  packed ghost centre Y.
- Size_ghost  in  N_GHOSTS*COORD_W  packed ghost half-size.
- Ghost_frightened  in  N_GHOSTS  ghost i is edible.
- X_pac, Y_pac, Size_pac  in  COORD_W each  Pac-Man centre and half-size.
- Not_ate  in  N_PELLETS  1 = pellet still present.
- Restart  in  1  level-sensitive; sampled on Frame_tick.
- Kill  out  1  game over, sticky.
- Win  out  1  all pellets eaten, sticky.
- Lives  out  LIVES_W  remaining lives.
- Life_lost  out  1  one-cycle pulse.
- Ghost_eaten  out  N_GHOSTS  one-cycle pulse per captured ghost.
- Respawn  out  1  one-cycle pulse when PAUSE ends.
- State  out  2  0=PLAY, 1=PAUSE, 2=OVER, 3=WIN.

Behaviour:
- **Clock and reset:** one clock; reset is asynchronous and active-low.
- **Reset values:** State=PLAY, Lives=START_LIVES, pause counter=0. Kill, Win, Life_lost, Ghost_eaten and Respawn all 0.
- **Bounding-box arithmetic:** extents are computed at COORD_W+1 bits.
  - left/top = centre−size, saturated at 0 on underflow.
  - right/bottom = centre+size, carry kept (no wrap).
- **Overlap test:** overlap[i] is true unless any of: pac_left>g_right, pac_top>g_bottom, pac_right<g_left, pac_bottom<g_top. Edges that touch count as overlap.
- Define lethal = overlap & ~Ghost_frightened and capture = overlap & Ghost_frightened.
- **Timing:** all registered outputs update on the Clk edge where Frame_tick=1; latency is 1 cycle. Pulse outputs return to 0 on the next cycle. Nothing changes when Frame_tick=0.
- **PLAY (on Frame_tick), evaluated in priority order:**
  1. Restart=1 → reload Lives, stay in PLAY.
  2. Any lethal bit set → Life_lost=1, Ghost_eaten=0.
     - If Lives==1: Lives=0, go to OVER, Kill=1.
     - Otherwise: Lives−1, pause counter=PAUSE_FRAMES−1, go to PAUSE.
  3. Not_ate all zero → go to WIN, Win=1. Ghost_eaten=capture on the same tick.
  4. Otherwise → Ghost_eaten=capture.
- **PAUSE (on Frame_tick):**
  - Collisions and pellets are ignored.
  - Restart → PLAY with Lives reloaded, no Respawn pulse.
  - Counter==0 → Respawn=1, go to PLAY.
  - Otherwise decrement the counter.
- **OVER / WIN:** sticky. Kill and Win stay held. Only Restart on Frame_tick leaves these states: → PLAY, Kill=Win=0, Lives=START_LIVES, counter cleared.
- **Boundary cases:**
  - Lives never underflows. START_LIVES=0 is illegal.
  - Reset asserted mid-PAUSE or in OVER returns to PLAY with reset values immediately (asynchronous).

Optional Feature:
- Macro GAME_STATE_EXTRA_LIFE_EN.
- **Defined:** an internal counter accumulates popcount(capture) on each PLAY tick.
  - When it first reaches ≥EXTRA_LIFE_GHOSTS, Lives increments by 1, saturating at 2^LIVES_W−1.
  - Awarded once per game; the counter and award flag clear on Restart and reset.
  - If a lethal hit and the threshold occur on the same tick, the lethal hit wins and no award is given that tick.
- **Undefined:** no counter is built; Lives changes only by lethal hits, Restart and reset.

Test Plan:
1. Reset_n low then high, no overlap, Not_ate all ones, 10 Frame_ticks → State=0, Lives=3, Kill=0, Win=0.
2. Ghost 2 at (100,100) size 8, Pac at (110,100) size 8, not frightened, one Frame_tick → Life_lost pulse, Lives=2, State=1. After 60 ticks: Respawn pulse, State=0.
3. Three successive lethal hits, each followed by the pause → third hit gives Lives=0, State=2, Kill=1 held across 20 more ticks. Restart on a tick → Kill=0, Lives=3, State=0.
4. Ghosts 0 and 3 overlapping and frightened, ghost 1 overlapping and not frightened, on the same tick → Life_lost=1, Ghost_eaten=4'b0000.
5. Not_ate=0 with ghost 1 overlapping and frightened → Win=1, Ghost_eaten=4'b0010, State=3. A later lethal overlap has no effect.
6. Pac at X=3, size 8 (left saturates to 0), ghost at X=0, size 2 → overlap detected, no wrap-induced miss.
